// File: rtl/exec_datapath_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exec_datapath_pipe                                              |
// | Brief    : two-stage execute datapath: dual-write regfile, barrel shifter, |
// |            ALU and NZCV status, with same-edge read bypass                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module exec_datapath_pipe #(
   parameter int  DATA_WIDTH = 32,
   parameter int  NUM_REGS   = 16,
   parameter int  SA         = $clog2(DATA_WIDTH),
   localparam int RA         = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [RA-1:0]         a_addr,
   input  logic [RA-1:0]         b_addr,
   input  logic [RA-1:0]         s_addr,
   input  logic                  sel_a,
   input  logic                  sel_b,
   input  logic                  sel_shift,
   input  logic [1:0]            shift_op,
   input  logic [SA-1:0]         shift_imm,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [2:0]            alu_op,
   input  logic                  set_flags,
   input  logic                  wr_en,
   input  logic [RA-1:0]         wr_addr,
   input  logic                  ext_wr_en,
   input  logic [RA-1:0]         ext_wr_addr,
   input  logic [DATA_WIDTH-1:0] ext_wr_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] result,
   output logic [3:0]            status_out
);

   localparam int DW = DATA_WIDTH;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;
   localparam logic [2:0] ALU_MOV = 3'b101;
   localparam logic [2:0] ALU_MVN = 3'b110;
   localparam logic [2:0] ALU_ADC = 3'b111;

   logic [DW-1:0] regs_q [NUM_REGS];
   logic [DW-1:0] regs_d [NUM_REGS];

   logic          v1_q, v1_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] imm_q, imm_d;
   logic [SA-1:0] amt_q, amt_d;
   logic          sel_b_q, sel_b_d;
   logic [1:0]    shift_op_q, shift_op_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic          set_flags_q, set_flags_d;
   logic          wr_en_q, wr_en_d;
   logic [RA-1:0] wr_addr_q, wr_addr_d;

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] result_q, result_d;
   logic [3:0]    status_q, status_d;

   logic          w_wb_en;
   logic [DW-1:0] w_rd_a, w_rd_b;
   logic [SA-1:0] w_rd_s;

   logic [DW:0]        w_lsl_ext;
   logic [DW:0]        w_rsh_ext;
   logic signed [DW:0] w_asr_ext;
   logic [SA:0]        w_ror_amt;
   logic [DW-1:0]      w_sh_out;
   logic               w_sh_c;

   logic [DW-1:0] w_b_op, w_addend, w_res;
   logic          w_cin, w_ovf, w_is_arith;
   logic [DW:0]   w_sum;
   logic [3:0]    w_flags;

   // Same-edge bypass: the external load port overrides ALU writeback.
   always_comb begin
      w_wb_en = v1_q & wr_en_q;

      w_rd_a = regs_q[a_addr];
      if (w_wb_en && (wr_addr_q == a_addr))      w_rd_a = w_res;
      if (ext_wr_en && (ext_wr_addr == a_addr))  w_rd_a = ext_wr_data;

      w_rd_b = regs_q[b_addr];
      if (w_wb_en && (wr_addr_q == b_addr))      w_rd_b = w_res;
      if (ext_wr_en && (ext_wr_addr == b_addr))  w_rd_b = ext_wr_data;

      w_rd_s = regs_q[s_addr][SA-1:0];
      if (w_wb_en && (wr_addr_q == s_addr))      w_rd_s = w_res[SA-1:0];
      if (ext_wr_en && (ext_wr_addr == s_addr))  w_rd_s = ext_wr_data[SA-1:0];
   end

   always_comb begin
      v1_d        = in_valid;
      a_d         = sel_a ? '0 : w_rd_a;
      b_d         = w_rd_b;
      amt_d       = sel_shift ? w_rd_s : shift_imm;
      imm_d       = imm;
      sel_b_d     = sel_b;
      shift_op_d  = shift_op;
      alu_op_d    = alu_op;
      set_flags_d = set_flags;
      wr_en_d     = wr_en;
      wr_addr_d   = wr_addr;
   end

   // Extra bit beyond the data catches the last bit shifted out.
   always_comb begin
      w_lsl_ext = {1'b0, b_q} << amt_q;
      w_rsh_ext = {b_q, 1'b0} >> amt_q;
      w_asr_ext = $signed({b_q, 1'b0}) >>> amt_q;
      w_ror_amt = (SA+1)'(DATA_WIDTH) - {1'b0, amt_q};
      w_sh_out  = b_q;
      w_sh_c    = status_q[1];
      if (amt_q != '0) begin
         case (shift_op_q)
            SH_LSL: begin
               w_sh_out = w_lsl_ext[DW-1:0];
               w_sh_c   = w_lsl_ext[DW];
            end
            SH_LSR: begin
               w_sh_out = w_rsh_ext[DW:1];
               w_sh_c   = w_rsh_ext[0];
            end
            SH_ASR: begin
               w_sh_out = w_asr_ext[DW:1];
               w_sh_c   = w_asr_ext[0];
            end
            default: begin
               w_sh_out = (b_q >> amt_q) | (b_q << w_ror_amt);
               w_sh_c   = b_q[amt_q - 1'b1];
            end
         endcase
      end
   end

   // SUB is A + ~B + 1 so the adder carry-out is directly NOT borrow.
   always_comb begin
      w_b_op     = sel_b_q ? imm_q : w_sh_out;
      w_addend   = (alu_op_q == ALU_SUB) ? ~w_b_op : w_b_op;
      w_cin      = (alu_op_q == ALU_SUB) | ((alu_op_q == ALU_ADC) & status_q[1]);
      w_sum      = {1'b0, a_q} + {1'b0, w_addend} + {{DW{1'b0}}, w_cin};
      w_ovf      = (a_q[DW-1] == w_addend[DW-1]) && (w_sum[DW-1] != a_q[DW-1]);
      w_is_arith = 1'b0;
      case (alu_op_q)
         ALU_ADD, ALU_SUB, ALU_ADC: begin
            w_res      = w_sum[DW-1:0];
            w_is_arith = 1'b1;
         end
         ALU_AND: w_res = a_q & w_b_op;
         ALU_ORR: w_res = a_q | w_b_op;
         ALU_EOR: w_res = a_q ^ w_b_op;
         ALU_MOV: w_res = w_b_op;
         ALU_MVN: w_res = ~w_b_op;
         default: w_res = w_b_op;
      endcase
      w_flags = {w_res[DW-1],
                 (w_res == '0),
                 w_is_arith ? w_sum[DW] : w_sh_c,
                 w_is_arith ? w_ovf     : status_q[0]};
   end

   always_comb begin
      regs_d = regs_q;
      if (w_wb_en)   regs_d[wr_addr_q]   = w_res;
      if (ext_wr_en) regs_d[ext_wr_addr] = ext_wr_data;

      out_valid_d = v1_q;
      result_d    = v1_q ? w_res : result_q;
      status_d    = (v1_q && set_flags_q) ? w_flags : status_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         v1_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         amt_q       <= '0;
         sel_b_q     <= 1'b0;
         shift_op_q  <= '0;
         alu_op_q    <= '0;
         set_flags_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         status_q    <= '0;
      end else begin
         regs_q      <= regs_d;
         v1_q        <= v1_d;
         a_q         <= a_d;
         b_q         <= b_d;
         imm_q       <= imm_d;
         amt_q       <= amt_d;
         sel_b_q     <= sel_b_d;
         shift_op_q  <= shift_op_d;
         alu_op_q    <= alu_op_d;
         set_flags_q <= set_flags_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         status_q    <= status_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign status_out = status_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_datapath_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_exec_datapath_pipe                                           |
// | Brief    : bench for exec_datapath_pipe: in-order op model plus literals   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps

module tb_exec_datapath_pipe;

   localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;
   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MOV = 3'd5, ADC = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  a_addr = '0, b_addr = '0, s_addr = '0, wr_addr = '0, ext_wr_addr = '0;
   logic        sel_a = 1'b0, sel_b = 1'b0, sel_shift = 1'b0;
   logic [1:0]  shift_op = '0;
   logic [4:0]  shift_imm = '0;
   logic [31:0] imm = '0, ext_wr_data = '0;
   logic [2:0]  alu_op = '0;
   logic        set_flags = 1'b0, wr_en = 1'b0, ext_wr_en = 1'b0;
   logic        out_valid;
   logic [31:0] result;
   logic [3:0]  status_out;

   always #5 clk = ~clk;

   exec_datapath_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a_addr(a_addr), .b_addr(b_addr), .s_addr(s_addr),
      .sel_a(sel_a), .sel_b(sel_b), .sel_shift(sel_shift),
      .shift_op(shift_op), .shift_imm(shift_imm), .imm(imm),
      .alu_op(alu_op), .set_flags(set_flags), .wr_en(wr_en), .wr_addr(wr_addr),
      .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
      .out_valid(out_valid), .result(result), .status_out(status_out)
   );

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   // Architectural model: ops execute in issue order; each one's result,
   // writeback and flags become visible one edge after it is accepted.
   logic [31:0] m_regs [16];
   logic [3:0]  m_st;
   logic        p_valid = 1'b0, p_wr, p_fl;
   logic [3:0]  p_addr, p_st;
   logic [31:0] p_res;
   logic        e_valid = 1'b0;
   logic [31:0] e_res = '0;

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic shift_model(input logic [31:0] b, input logic [1:0] op, input int n,
                              input logic cin, output logic [31:0] r, output logic c);
      r = b;
      c = cin;
      for (int i = 0; i < n; i++) begin
         case (op)
            LSL:     begin c = r[31]; r = {r[30:0], 1'b0}; end
            LSR:     begin c = r[0];  r = {1'b0, r[31:1]}; end
            ASR:     begin c = r[0];  r = {r[31], r[31:1]}; end
            default: begin c = r[0];  r = {r[0], r[31:1]}; end
         endcase
      end
   endtask

   task automatic alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [3:0] st, input logic shc,
                            output logic [31:0] r, output logic [3:0] nst);
      longint ua, ub, s, sa, sb, ss;
      logic c, v;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c  = shc;
      v  = st[0];
      s  = 0;
      case (op)
         3'd0: begin s = ua + ub; ss = sa + sb; end
         3'd1: begin s = ua - ub; ss = sa - sb; end
         3'd7: begin s = ua + ub + longint'(st[1]); ss = sa + sb + longint'(st[1]); end
         default: ss = 0;
      endcase
      case (op)
         3'd0, 3'd7: begin r = s[31:0]; c = s[32]; end
         3'd1:       begin r = s[31:0]; c = (ua >= ub); end
         3'd2:       r = a & b;
         3'd3:       r = a | b;
         3'd4:       r = a ^ b;
         3'd5:       r = b;
         default:    r = ~b;
      endcase
      if (op == 3'd0 || op == 3'd1 || op == 3'd7)
         v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      nst = {r[31], (r == 32'd0), c, v};
   endtask

   task automatic model_step();
      logic [31:0] a, b, bs, r;
      logic        shc;
      logic [3:0]  ns;
      int          n;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_st    = '0;
         p_valid = 1'b0;
         e_valid = 1'b0;
         e_res   = '0;
         chk_en  = 1'b1;
         return;
      end
      e_valid = p_valid;
      if (p_valid) begin
         e_res = p_res;
         if (p_wr) m_regs[p_addr] = p_res;
         if (p_fl) m_st = p_st;
      end
      if (ext_wr_en) m_regs[ext_wr_addr] = ext_wr_data;
      p_valid = in_valid;
      if (in_valid) begin
         a = sel_a ? 32'd0 : m_regs[a_addr];
         n = sel_shift ? int'(m_regs[s_addr] % 32) : int'(shift_imm);
         shift_model(m_regs[b_addr], shift_op, n, m_st[1], bs, shc);
         b = sel_b ? imm : bs;
         alu_model(a, b, alu_op, m_st, shc, r, ns);
         p_res  = r;
         p_wr   = wr_en;
         p_addr = wr_addr;
         p_fl   = set_flags;
         p_st   = ns;
      end
   endtask

   task automatic check_outputs();
      if (!chk_en) return;
      cmp("model_out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      cmp("model_status", {28'd0, status_out}, {28'd0, m_st});
      if (e_valid) cmp("model_result", result, e_res);
   endtask

   task automatic clk_step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_idle();
      in_valid  = 1'b0;
      ext_wr_en = 1'b0;
   endtask

   task automatic issue(input logic i_sa, input logic [3:0] i_aa, input logic [3:0] i_ba,
                        input logic [3:0] i_saddr, input logic i_sb, input logic i_ss,
                        input logic [1:0] i_sop, input logic [4:0] i_simm, input logic [31:0] i_imm,
                        input logic [2:0] i_alu, input logic i_sf, input logic i_we,
                        input logic [3:0] i_wa);
      in_valid  = 1'b1;
      sel_a     = i_sa;      a_addr    = i_aa;
      b_addr    = i_ba;      s_addr    = i_saddr;
      sel_b     = i_sb;      sel_shift = i_ss;
      shift_op  = i_sop;     shift_imm = i_simm;
      imm       = i_imm;     alu_op    = i_alu;
      set_flags = i_sf;      wr_en     = i_we;
      wr_addr   = i_wa;
      clk_step();
   endtask

   task automatic ext_load(input logic [3:0] addr, input logic [31:0] data);
      set_idle();
      ext_wr_en   = 1'b1;
      ext_wr_addr = addr;
      ext_wr_data = data;
      clk_step();
      ext_wr_en = 1'b0;
   endtask

   task automatic finish_op(input string nm, input logic [31:0] er, input logic [3:0] es);
      set_idle();
      clk_step();
      cmp({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
      cmp(nm, result, er);
      cmp({nm, "_nzcv"}, {28'd0, status_out}, {28'd0, es});
   endtask

   initial begin
      rst = 1'b1;
      clk_step();
      clk_step();
      cmp("reset_out_valid", {31'd0, out_valid}, 32'd0);
      cmp("reset_status", {28'd0, status_out}, 32'd0);

      // Dirty the state, then reset again.
      rst = 1'b0;
      ext_load(4'd1, 32'h0000_1234);
      issue(1, 0, 0, 0, 1, 0, LSL, 0, 32'h8000_0000, MOV, 1, 1, 4'd2);
      set_idle();
      clk_step();
      rst = 1'b1;
      clk_step();
      cmp("dirty_reset_status", {28'd0, status_out}, 32'd0);
      cmp("dirty_reset_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      issue(0, 0, 4'd1, 0, 0, 0, LSL, 0, 0, MOV, 0, 0, 0);
      finish_op("reset_cleared_r1", 32'd0, 4'b0000);

      // reg[i] = i, results trailing their issue by two edges.
      for (int i = 0; i < 16; i++) begin
         issue(1, 0, 0, 0, 1, 0, LSL, 0, 32'(i), ADD, 0, 1, 4'(i));
         if (i > 0) cmp("init_result", result, 32'(i - 1));
      end
      set_idle();
      clk_step();
      cmp("init_last", result, 32'd15);
      for (int i = 0; i < 16; i++) begin
         issue(0, 0, 4'(i), 0, 0, 0, LSL, 0, 0, MOV, 0, 0, 0);
         if (i > 0) cmp("readback", result, 32'(i - 1));
      end
      finish_op("readback_r15", 32'd15, 4'b0000);

      issue(0, 4'd1, 4'd2, 0, 0, 0, LSL, 5'd1, 0, ADD, 1, 0, 0);
      finish_op("add_r1_r2lsl1", 32'd5, 4'b0000);

      // SUB into r0 followed immediately by a dependent ADD.
      issue(1, 0, 0, 0, 1, 0, LSL, 0, 32'd12, SUB, 1, 1, 4'd0);
      issue(0, 4'd0, 4'd2, 0, 0, 0, LSL, 5'd2, 0, ADD, 0, 0, 0);
      cmp("sub_imm12", result, 32'hFFFF_FFF4);
      cmp("sub_imm12_nzcv", {28'd0, status_out}, 32'h8);
      finish_op("bypass_add", 32'hFFFF_FFFC, 4'b1000);

      // ALU and load port hit r3 on the same edge; the load wins.
      issue(1, 0, 0, 0, 1, 0, LSL, 0, 32'd7, ADD, 0, 1, 4'd3);
      ext_wr_en   = 1'b1;
      ext_wr_addr = 4'd3;
      ext_wr_data = 32'h0000_DEAD;
      issue(0, 0, 4'd3, 0, 0, 0, LSL, 0, 0, MOV, 0, 0, 0);
      ext_wr_en = 1'b0;
      issue(0, 0, 4'd3, 0, 0, 0, LSL, 0, 0, MOV, 0, 0, 0);
      cmp("conflict_bypass", result, 32'h0000_DEAD);
      finish_op("conflict_reg", 32'h0000_DEAD, 4'b1000);

      ext_load(4'd4, 32'h8000_0001);
      ext_load(4'd5, 32'h0000_0020);
      ext_load(4'd6, 32'hFFFF_FFFF);
      issue(1, 0, 4'd4, 0, 0, 0, ASR, 5'd1, 0, MOV, 1, 0, 0);
      finish_op("asr1", 32'hC000_0000, 4'b1010);
      issue(1, 0, 4'd4, 4'd5, 0, 1, ROR, 5'd9, 0, MOV, 1, 0, 0);
      finish_op("reg_amount_zero", 32'h8000_0001, 4'b1010);
      issue(1, 0, 4'd4, 0, 0, 0, ROR, 5'd4, 0, MOV, 1, 0, 0);
      finish_op("ror4", 32'h1800_0000, 4'b0000);
      issue(0, 4'd6, 0, 0, 1, 0, LSL, 0, 32'd1, ADD, 1, 0, 0);
      finish_op("add_wrap", 32'd0, 4'b0110);
      issue(1, 0, 0, 0, 1, 0, LSL, 0, 32'd5, ADC, 1, 0, 0);
      finish_op("adc_cin", 32'd6, 4'b0000);
      issue(1, 0, 4'd4, 0, 0, 0, LSL, 5'd1, 0, MOV, 1, 0, 0);
      finish_op("lsl1_carry", 32'h0000_0002, 4'b0010);
      issue(1, 0, 4'd4, 0, 0, 0, LSR, 5'd31, 0, MOV, 1, 0, 0);
      finish_op("lsr31", 32'h0000_0001, 4'b0000);

      // Reset lands on the edge where the op would retire.
      issue(1, 0, 0, 0, 1, 0, LSL, 0, 32'h8000_0000, ADD, 1, 1, 4'd9);
      set_idle();
      rst = 1'b1;
      clk_step();
      cmp("rst_midop_valid", {31'd0, out_valid}, 32'd0);
      cmp("rst_midop_status", {28'd0, status_out}, 32'd0);
      rst = 1'b0;
      clk_step();
      cmp("rst_midop_valid_after", {31'd0, out_valid}, 32'd0);
      issue(0, 0, 4'd9, 0, 0, 0, LSL, 0, 0, MOV, 0, 0, 0);
      finish_op("rst_midop_r9", 32'd0, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
